// File: rtl/fft_bin_abs.sv
// Frame tracker and absolute-value front end for the FFT spectrum path.
// Forwards |real|/|imag| of the lowest 2^ADDR_WIDTH bins of each frame with a bin address and write strobe.
module fft_bin_abs #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 18,
    parameter int FFT_POINTS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    input  logic                  src_sop,
    input  logic                  src_eop,
    input  logic [DATA_WIDTH-1:0] src_real,
    input  logic [DATA_WIDTH-1:0] src_imag,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] abs_r,
    output logic [DATA_WIDTH-1:0] abs_i,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CNT_W = (FFT_POINTS > 1) ? $clog2(FFT_POINTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_POINTS - 1);
    localparam int unsigned FWD_BINS = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] bin_idx;
    logic             accept;
    logic             done_n;
    logic             err_n;
    logic             fwd;

    // Saturating abs keeps the output MSB clear; downstream relies on that headroom.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
        if (!x[DATA_WIDTH-1])
            return x;
        else if (x == MOST_NEG)
            return MOST_POS;
        else
            return DATA_WIDTH'(-x);
    endfunction

    // src_valid qualifies sop/eop/data on the same cycle; there is no backpressure.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bin_idx = cnt;
        accept  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (src_valid && src_sop) begin
                    accept  = 1'b1;
                    bin_idx = '0;
                    if (src_eop) begin
                        err_n = 1'b1;
                        cnt_n = '0;
                    end else begin
                        state_n = RUN;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (src_valid) begin
                    accept = 1'b1;
                    if (src_sop) begin
                        err_n   = 1'b1;
                        bin_idx = '0;
                        cnt_n   = CNT_W'(1);
                    end else if (src_eop) begin
                        done_n  = (cnt == LAST_BIN);
                        err_n   = (cnt != LAST_BIN);
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == LAST_BIN) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign fwd = accept && (32'(bin_idx) < FWD_BINS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we         <= 1'b0;
            addr       <= '0;
            abs_r      <= '0;
            abs_i      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            we         <= fwd;
            frame_done <= done_n;
            frame_err  <= err_n;
            if (fwd) begin
                addr  <= bin_idx[ADDR_WIDTH-1:0];
                abs_r <= abs_sat(src_real);
                abs_i <= abs_sat(src_imag);
            end
        end
    end

endmodule

// File: tb/tb_fft_bin_abs.sv
// Directed bench for fft_bin_abs: vector table for abs corners and framing, plus full-frame sequences.
module tb_fft_bin_abs;

    logic        clk;
    logic        rst;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic [17:0] src_real;
    logic [17:0] src_imag;
    logic        we;
    logic [5:0]  addr;
    logic [17:0] abs_r;
    logic [17:0] abs_i;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    fft_bin_abs #(.ADDR_WIDTH(6), .DATA_WIDTH(18), .FFT_POINTS(128)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag),
        .we(we), .addr(addr), .abs_r(abs_r), .abs_i(abs_i),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic        e;
        logic [17:0] re;
        logic [17:0] im;
        logic        we;
        logic [5:0]  addr;
        logic [17:0] ar;
        logic [17:0] ai;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply one input cycle; outputs for it are visible 1 time unit after the edge.
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [17:0] re, input logic [17:0] im);
        src_valid = v;
        src_sop   = s;
        src_eop   = e;
        src_real  = re;
        src_imag  = im;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_abs_r"}, 32'(abs_r), 0);
        check({tag, "_abs_i"}, 32'(abs_i), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_err"}, 32'(frame_err), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        drive(0, 0, 0, 18'd0, 18'd0);
        drive(0, 0, 0, 18'd0, 18'd0);
        check_zero(tag);
        rst = 1'b1;
    endtask

    // Beat k of a frame carrying real=k, imag=-k; bins >= 64 must leave addr holding 63.
    task automatic frame_beat(input string tag, input int k, input logic s, input logic e,
                              input logic exp_done, input logic exp_err);
        logic [17:0] re, im;
        re = 18'(k);
        im = 18'(-k);
        drive(1, s, e, re, im);
        check({tag, "_we"}, 32'(we), (k < 64) ? 1 : 0);
        if (k < 64) begin
            check({tag, "_addr"}, 32'(addr), 32'(k));
            check({tag, "_abs_r"}, 32'(abs_r), 32'(k));
            check({tag, "_abs_i"}, 32'(abs_i), 32'(k));
        end else begin
            check({tag, "_addr_hold"}, 32'(addr), 63);
        end
        check({tag, "_done"}, 32'(frame_done), 32'(exp_done));
        check({tag, "_err"}, 32'(frame_err), 32'(exp_err));
    endtask

    task automatic full_frame(input string tag);
        for (int k = 0; k < 128; k++)
            frame_beat(tag, k, k == 0, k == 127, k == 127, 1'b0);
    endtask

    initial begin
        int k;
        int cyc;
        logic v;

        rst = 1'b0;
        src_valid = 0; src_sop = 0; src_eop = 0; src_real = '0; src_imag = '0;

        // Start in IDLE; each row is one cycle and the expected outputs one cycle later.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 18'h20000, 18'h1ffff, 1'b1, 6'd0, 18'd131071, 18'd131071, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 18'd5,     18'd5,     1'b0, 6'd0, 18'd131071, 18'd131071, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 18'h3ffff, 18'd0,     1'b1, 6'd1, 18'd1,      18'd0,      1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 18'd131071, 18'h20001, 1'b1, 6'd2, 18'd131071, 18'd131071, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 18'd7,     18'h3fff8, 1'b1, 6'd0, 18'd7,      18'd8,      1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 18'd3,     18'd3,     1'b1, 6'd1, 18'd3,      18'd3,      1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 18'd9,     18'd9,     1'b0, 6'd1, 18'd3,      18'd3,      1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 18'h3fffe, 18'd2,     1'b1, 6'd0, 18'd2,      18'd2,      1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 18'd0,     18'h20000, 1'b1, 6'd0, 18'd0,      18'd131071, 1'b0, 1'b0};

        do_reset("reset");

        full_frame("t1");

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].re, vecs[i].im);
            check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].we));
            check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_abs_r", i), 32'(abs_r), 32'(vecs[i].ar));
            check($sformatf("vec%0d_abs_i", i), 32'(abs_i), 32'(vecs[i].ai));
            check($sformatf("vec%0d_done", i), 32'(frame_done), 32'(vecs[i].done));
            check($sformatf("vec%0d_err", i), 32'(frame_err), 32'(vecs[i].err));
        end

        do_reset("reset2");

        // Random valid gaps; sop/eop on invalid cycles must be ignored.
        k = 0;
        cyc = 0;
        while (k < 128 && cyc < 2000) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                frame_beat("t3", k, k == 0, k == 127, k == 127, 1'b0);
                k++;
            end else begin
                drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      18'($urandom), 18'($urandom));
                check("t3_gap_we", 32'(we), 0);
                check("t3_gap_done", 32'(frame_done), 0);
                check("t3_gap_err", 32'(frame_err), 0);
            end
            cyc++;
        end
        check("t3_frame_complete", 32'(k), 128);

        // Early eop at beat 99, then a sop-less beat is dropped.
        for (int j = 0; j < 100; j++)
            frame_beat("t4", j, j == 0, j == 99, 1'b0, j == 99);
        drive(1, 0, 0, 18'd20, 18'd20);
        check("t4_orphan_we", 32'(we), 0);
        check("t4_orphan_addr", 32'(addr), 63);
        check("t4_orphan_err", 32'(frame_err), 0);
        check("t4_orphan_done", 32'(frame_done), 0);

        // Restart with sop at beat 40, then complete the new frame cleanly.
        for (int j = 0; j < 40; j++)
            frame_beat("t5a", j, j == 0, 1'b0, 1'b0, 1'b0);
        frame_beat("t5_restart", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j < 128; j++)
            frame_beat("t5b", j, 1'b0, j == 127, j == 127, 1'b0);

        // Reset mid-frame at beat 20, sop-less beat ignored, then a fresh frame.
        for (int j = 0; j < 20; j++)
            frame_beat("t6a", j, j == 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1, 0, 0, 18'd20, 18'h3ffec);
        check_zero("t6_rst");
        rst = 1'b1;
        drive(1, 0, 0, 18'd5, 18'h3fffb);
        check_zero("t6_orphan");
        full_frame("t6b");

        drive(0, 0, 0, 18'd0, 18'd0);
        check("tail_done", 32'(frame_done), 0);
        check("tail_we", 32'(we), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
